// File: rtl/subbytes_shiftrows_serial_if.sv
// Handshake bundle for the byte-serial SubBytes/ShiftRows stage: an input
// state channel, an output state channel and a busy indicator.
interface subbytes_shiftrows_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    // Side that produces input states and consumes results.
    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    // The round stage itself.
    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/subbytes_shiftrows_serial.sv
// Byte-serial AES SubBytes + ShiftRows. One state is captured, its 16 bytes
// are pushed through a single sbox, one byte per cycle, and each substituted
// byte lands directly in its ShiftRows position of the output register.
module subbytes_shiftrows_serial #(
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    subbytes_shiftrows_serial_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     k_q, k_d;
    logic [127:0]   src_q, src_d;
    logic [127:0]   out_q, out_d;

    logic [7:0]     sub_in;
    logic [7:0]     sub_out;
    logic [1:0]     dst_col;
    logic [3:0]     dst_idx;

    // Byte k sits at bits 127-8k; {~k, 3'b111} is that MSB index.
    assign sub_in  = src_q[{~k_q, 3'b111} -: 8];
    // ShiftRows moves row r left by r: source column c lands in column c-r.
    assign dst_col = k_q[3:2] - k_q[1:0];
    assign dst_idx = SHIFT_EN ? {dst_col, k_q[1:0]} : k_q;

    sbox u_sbox (
        .input_byte  (sub_in),
        .output_byte (sub_out)
    );

    // Next-state, counter, capture and write-back logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        k_d     = k_q;
        src_d   = src_q;
        out_d   = out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    src_d   = bus.in_state;
                    k_d     = 4'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                out_d[{~dst_idx, 3'b111} -: 8] = sub_out;
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-operation drops the partial result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the 128-bit result/source registers are plain flops, so they are reset to a known zero.
            state_q <= ST_IDLE;
            k_q     <= 4'd0;
            src_q   <= 128'h0;
            out_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            src_q   <= src_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_BUSY);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_state = out_q;

endmodule

// Combinational AES forward S-box, table driven. Entry x sits at bits 2047-8x.
module sbox (
    input  logic [7:0] input_byte,
    output logic [7:0] output_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign output_byte = SBOX_TABLE[{~input_byte, 3'b111} -: 8];

endmodule

// File: tb/tb_subbytes_shiftrows_serial.sv
// Bench for subbytes_shiftrows_serial: two instances (ShiftRows on and off)
// driven in lockstep, expected results from an algebraic S-box model queued
// at stimulus time and compared when each instance hands a result out.
module tb_subbytes_shiftrows_serial;

    logic clk;
    logic rst;

    subbytes_shiftrows_serial_if if1 ();
    subbytes_shiftrows_serial_if if0 ();

    subbytes_shiftrows_serial #(.SHIFT_EN(1'b1)) dut_shift (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    subbytes_shiftrows_serial #(.SHIFT_EN(1'b0)) dut_plain (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    int total = 0;
    int bad   = 0;

    logic [127:0] exp1_q[$];
    logic [127:0] exp0_q[$];

    localparam logic [127:0] VEC_SEQ   = 128'h0102030405060708090a0b0c0d0e0f10;
    localparam logic [127:0] EXP_SEQ_1 = 128'h7c6f2bca6b6776f201ab7b30d777c5fe;
    localparam logic [127:0] EXP_SEQ_0 = 128'h7c777bf26b6fc53001672bfed7ab76ca;
    localparam logic [127:0] VEC_ONES  = {16{8'h01}};
    localparam logic [127:0] EXP_ONES  = {16{8'h7c}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (0 maps to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] model_sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gf_mul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s, input bit shift);
        logic [127:0] o;
        int           src_c;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src_c = shift ? (c + r) % 4 : c;
                o[127 - 8 * (r + 4 * c) -: 8] = model_sbox(s[127 - 8 * (r + 4 * src_c) -: 8]);
            end
        end
        return o;
    endfunction

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        #1;
        if (if1.out_valid && if1.out_ready) begin
            if (exp1_q.size() == 0) begin
                bad++;
                $display("FAIL shift_unexpected_output: got %h with no pending expectation", if1.out_state);
            end else begin
                check("shift_out_state", if1.out_state, exp1_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (if0.out_valid && if0.out_ready) begin
            if (exp0_q.size() == 0) begin
                bad++;
                $display("FAIL plain_unexpected_output: got %h with no pending expectation", if0.out_state);
            end else begin
                check("plain_out_state", if0.out_state, exp0_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_in(input logic v, input logic [127:0] s);
        if1.in_valid = v;
        if1.in_state = s;
        if0.in_valid = v;
        if0.in_state = s;
    endtask

    task automatic drive_out_ready(input logic v);
        if1.out_ready = v;
        if0.out_ready = v;
    endtask

    // Called at a negedge with in_valid already high; returns at the negedge
    // right after the accepting edge.
    task automatic wait_accept();
        int n;
        n = 0;
        while (!if1.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", n, 0);
        @(negedge clk);
    endtask

    // Called at the negedge after acceptance; returns at the first negedge
    // with out_valid high and the number of cycles waited.
    task automatic wait_out_valid(input bit toggle, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (toggle) drive_in(1'b0, {$urandom, $urandom, $urandom, $urandom});
        end while (!if1.out_valid && lat < 100);
    endtask

    // Full operation with out_ready held high.
    task automatic run_op(input string tag, input logic [127:0] s,
                          input logic [127:0] e1, input logic [127:0] e0, input bit toggle);
        int lat;
        @(negedge clk);
        drive_out_ready(1'b1);
        drive_in(1'b1, s);
        exp1_q.push_back(e1);
        exp0_q.push_back(e0);
        wait_accept();
        drive_in(1'b0, toggle ? ~s : s);
        check({tag, "_busy"}, {if1.in_ready, if1.out_valid, if1.busy}, 3'b001);
        wait_out_valid(toggle, lat);
        check({tag, "_latency"}, lat, 16);
        check({tag, "_plain_valid"}, if0.out_valid, 1'b1);
        @(negedge clk);
        check({tag, "_back_idle"}, {if1.in_ready, if1.out_valid, if1.busy}, 3'b100);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] va;
        logic [127:0] vb;
        int           lat;

        rst = 1'b1;
        drive_in(1'b0, '0);
        drive_out_ready(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_flags", {if1.in_ready, if1.out_valid, if1.busy}, 3'b100);
            check("idle_out_state", if1.out_state | if0.out_state, 128'h0);
        end

        // Directed vectors.
        run_op("ones", VEC_ONES, EXP_ONES, EXP_ONES, 1'b0);
        run_op("seq", VEC_SEQ, EXP_SEQ_1, EXP_SEQ_0, 1'b0);

        // Backpressure with a second state waiting upstream.
        va = 128'h3243f6a8885a308d313198a2e0370734;
        vb = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk);
        drive_out_ready(1'b0);
        drive_in(1'b1, va);
        exp1_q.push_back(model_state(va, 1'b1));
        exp0_q.push_back(model_state(va, 1'b0));
        wait_accept();
        drive_in(1'b1, vb);
        exp1_q.push_back(model_state(vb, 1'b1));
        exp0_q.push_back(model_state(vb, 1'b0));
        wait_out_valid(1'b0, lat);
        check("bp_latency", lat, 16);
        for (int i = 0; i < 10; i++) begin
            check("bp_flags", {if1.in_ready, if1.out_valid, if1.busy}, 3'b010);
            check("bp_hold_shift", if1.out_state, model_state(va, 1'b1));
            check("bp_hold_plain", if0.out_state, model_state(va, 1'b0));
            @(negedge clk);
        end
        drive_out_ready(1'b1);
        @(negedge clk);
        check("bp_idle_gap", {if1.in_ready, if1.out_valid, if1.busy}, 3'b100);
        @(negedge clk);
        drive_in(1'b0, '0);
        check("bp_second_accepted", if1.busy, 1'b1);
        wait_out_valid(1'b0, lat);
        check("bp_second_latency", lat, 16);
        @(negedge clk);

        // Input changes during BUSY are ignored.
        va = {$urandom, $urandom, $urandom, $urandom};
        run_op("toggle", va, model_state(va, 1'b1), model_state(va, 1'b0), 1'b1);

        // Reset at byte k=7 discards the partial result.
        @(negedge clk);
        drive_in(1'b1, VEC_ONES);
        exp1_q.push_back(EXP_ONES);
        exp0_q.push_back(EXP_ONES);
        wait_accept();
        drive_in(1'b0, '0);
        repeat (7) @(negedge clk);
        check("rst_mid_busy", if1.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp1_q.delete();
        exp0_q.delete();
        check("rst_flags", {if1.in_ready, if1.out_valid, if1.busy}, 3'b100);
        check("rst_out_shift", if1.out_state, 128'h0);
        check("rst_out_plain", if0.out_state, 128'h0);
        run_op("post_rst", VEC_SEQ, EXP_SEQ_1, EXP_SEQ_0, 1'b0);

        // A few random states, including possible zero bytes.
        for (int i = 0; i < 3; i++) begin
            va = {$urandom, $urandom, $urandom, $urandom};
            run_op("rand", va, model_state(va, 1'b1), model_state(va, 1'b0), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("shift_queue_drained", exp1_q.size(), 0);
        check("plain_queue_drained", exp0_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
